mcpu_multicycle: RTL and testbench

Multi-cycle successor to the single-cycle MIPS core. It executes a MIPS-I subset through a five-state control FSM over one shared instruction/data memory port with a ready handshake, so memory latency may vary. Reset vector is parametrised, and the register file, ALU and write-back path are reused across states. It sits at the top of the CPU hierarchy, between the testbench/SoC and an external memory model.

---
 rtl/mcpu_pkg.sv | 59 +++++
 rtl/mcpu_alu.sv | 34 +++
 rtl/mcpu_multicycle.sv | 176 +++++++++++++++++
 tb/tb_mcpu_multicycle.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_pkg
// Brief    : Shared opcode/funct constants, ALU operation and FSM state types
//            for the multi-cycle MIPS-I subset core.
// Revision : 1.0 - initial release
// ============================================================================
package mcpu_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // True for the R-type funct codes this core implements
  function automatic logic funct_supported(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // Maps an R-type funct code onto the ALU operation
  function automatic alu_op_e alu_op_from_funct(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_alu
// Brief    : Combinational 32-bit ALU (add, sub, and, or, signed slt) with a
//            zero flag used for beq comparison.
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_alu
  import mcpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  // Result selection; arithmetic wraps at 32 bits
  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule
`default_nettype wire

// File: rtl/mcpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_multicycle
// Brief    : Multi-cycle MIPS-I subset core. Five-state control FSM sharing a
//            single instruction/data memory port with a ready handshake.
//            Optional feature macro: MCPU_JUMP_EN (enables op 0x02, j).
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_multicycle
  import mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic                  retire,
  output logic                  illegal
);

  state_e      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, t_q, r_q, mdr_q;
  logic        retire_q, illegal_q;
  logic [31:0] rf_q [32];

  // Instruction fields
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_sext, w_rs_val, w_rt_val, w_wb_val, w_addr_full;
  logic        w_unused;

  assign w_op     = ir_q[31:26];
  assign w_rs     = ir_q[25:21];
  assign w_rt     = ir_q[20:16];
  assign w_rd     = ir_q[15:11];
  assign w_funct  = ir_q[5:0];
  assign w_sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign w_unused = ^ir_q[10:6];

  // r0 is never written, but the explicit zero keeps the read path obvious
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : rf_q[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : rf_q[w_rt];
  assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wb_val = (w_op == OP_LW) ? mdr_q : r_q;

  logic    w_legal;
  alu_op_e w_alu_op;
  logic [31:0] w_alu_b, w_alu_res;
  logic        w_alu_zero;

  // Opcode legality and ALU operand/operation selection
  always_comb begin
    w_legal  = 1'b0;
    w_alu_op = ALU_ADD;
    w_alu_b  = w_sext;
    case (w_op)
      OP_RTYPE: begin
        w_legal  = funct_supported(w_funct);
        w_alu_op = alu_op_from_funct(w_funct);
        w_alu_b  = b_q;
      end
      OP_BEQ: begin
        w_legal  = 1'b1;
        w_alu_op = ALU_SUB;
        w_alu_b  = b_q;
      end
      OP_ADDI, OP_LW, OP_SW: w_legal = 1'b1;
`ifdef MCPU_JUMP_EN
      OP_J: w_legal = 1'b1;
`else
      OP_J: w_legal = 1'b0;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  mcpu_alu u_alu (
    .a_i      (a_q),
    .b_i      (w_alu_b),
    .op_i     (w_alu_op),
    .result_o (w_alu_res),
    .zero_o   (w_alu_zero)
  );

  // Memory port: driven purely from held registers so it stays stable during waits
  assign w_addr_full = (state_q == ST_FETCH) ? pc_q : {r_q[31:2], 2'b00};
  assign mem_addr    = w_addr_full[ADDR_WIDTH-1:0];
  assign mem_req     = ~rst & ((state_q == ST_FETCH) | (state_q == ST_MEM));
  assign mem_we      = ~rst & (state_q == ST_MEM) & (w_op == OP_SW);
  assign mem_wdata   = b_q;

  assign pc      = pc_q;
  assign retire  = retire_q;
  assign illegal = illegal_q;

  // Control FSM, datapath registers and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      t_q       <= '0;
      r_q       <= '0;
      mdr_q     <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q <= w_rs_val;
          b_q <= w_rt_val;
          t_q <= pc_q + {w_sext[29:0], 2'b00};
          if (!w_legal) begin
            illegal_q <= 1'b1;
            state_q   <= ST_FETCH;
          end else if (w_op == OP_J) begin
            pc_q     <= {pc_q[31:28], ir_q[25:0], 2'b00};
            retire_q <= 1'b1;
            state_q  <= ST_FETCH;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_q <= w_alu_res;
          if (w_op == OP_BEQ) begin
            if (w_alu_zero) pc_q <= t_q;
            retire_q <= 1'b1;
            state_q  <= ST_FETCH;
          end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (w_op == OP_SW) begin
              retire_q <= 1'b1;
              state_q  <= ST_FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= ST_WB;
            end
          end
        end
        ST_WB: begin
          if (w_dest != 5'd0) rf_q[w_dest] <= w_wb_val;
          retire_q <= 1'b1;
          state_q  <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_multicycle
// Brief    : Directed, table-driven bench for mcpu_multicycle with a word
//            memory model and hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_multicycle;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h2000_0000;  // addi r0,r0,0
  localparam logic [31:0] PROBE  = 32'hAC03_0040;  // sw r3,0x40(r0)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [31:0] mem [0:255];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  int ret_n;
  int ret_cyc [8];
  logic [31:0] ret_pc [8];
  int stall_left;
  logic [31:0] stall_addr;

  typedef struct {
    logic [31:0] setup;
    logic [31:0] instr;
    int          delta;
    logic [31:0] pc2;
    logic        ill;
    logic [31:0] m40;
  } vec_t;

  vec_t vecs [12];
  int   nv;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  mcpu_multicycle #(.RESET_PC(RST_PC), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .illegal   (illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[16] = 32'hDEAD_BEEF;
    mem[17] = 32'h0000_0000;
  endtask

  task automatic add_vec(input logic [31:0] s, input logic [31:0] ins, input int d,
                         input logic [31:0] p, input logic il, input logic [31:0] m);
    vecs[nv].setup = s;
    vecs[nv].instr = ins;
    vecs[nv].delta = d;
    vecs[nv].pc2   = p;
    vecs[nv].ill   = il;
    vecs[nv].m40   = m;
    nv++;
  endtask

  // Assert reset, check the reset state, release; leaves time at cycle-1 sample point
  task automatic do_reset();
    rst        = 1'b1;
    mem_ready  = 1'b1;
    stall_left = 0;
    stall_addr = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we},  32'd0);
    check("rst_pc",      pc,               RST_PC);
    check("rst_retire",  {31'd0, retire},  32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc   = 0;
    ret_n = 0;
  endtask

  // One clock of memory model + monitor, sampled 1 time unit after negedge
  task automatic step();
    cyc++;
    if (mem_req && !mem_we && mem_addr == stall_addr && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = 1'b1;
    end
    if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    if (retire && ret_n < 8) begin
      ret_cyc[ret_n] = cyc;
      ret_pc[ret_n]  = pc;
      ret_n++;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    int stable_cnt;
    mem_ready  = 1'b1;
    stall_left = 0;
    stall_addr = 32'hFFFF_FFFF;
    nv         = 0;

    // setup (addi r1,r0,imm), instr, CPI delta, next pc, illegal, word @0x40
    add_vec(32'h2001_0005, 32'h0021_1820, 4, 32'h108, 1'b0, 32'h0000_000A); // add r3,r1,r1
    add_vec(32'h2001_0005, 32'h0001_1822, 4, 32'h108, 1'b0, 32'hFFFF_FFFB); // sub r3,r0,r1
    add_vec(32'h2001_0005, 32'h0020_1824, 4, 32'h108, 1'b0, 32'h0000_0000); // and r3,r1,r0
    add_vec(32'h2001_0005, 32'h0020_1825, 4, 32'h108, 1'b0, 32'h0000_0005); // or  r3,r1,r0
    add_vec(32'h2001_0005, 32'h0001_182A, 4, 32'h108, 1'b0, 32'h0000_0001); // slt r3,r0,r1
    add_vec(32'h2001_FFFF, 32'h0020_182A, 4, 32'h108, 1'b0, 32'h0000_0001); // slt r3,r1,r0 (-1<0)
    add_vec(32'h2001_0005, 32'h2023_FFF9, 4, 32'h108, 1'b0, 32'hFFFF_FFFE); // addi r3,r1,-7
    add_vec(32'h2001_0005, 32'h1021_0002, 3, 32'h110, 1'b0, 32'hDEAD_BEEF); // beq r1,r1,+2
    add_vec(32'h2001_0005, 32'h1020_0002, 3, 32'h108, 1'b0, 32'h0000_0000); // beq r1,r0,+2
    add_vec(32'h2001_0005, 32'hFC00_0000, 6, 32'h10C, 1'b1, 32'h0000_0000); // op 0x3F
    add_vec(32'h2001_0005, 32'h0000_0000, 6, 32'h10C, 1'b1, 32'h0000_0000); // funct 0x00
`ifdef MCPU_JUMP_EN
    add_vec(32'h2001_0005, 32'h0800_0040, 2, 32'h100, 1'b0, 32'hDEAD_BEEF); // j 0x40
`else
    add_vec(32'h2001_0005, 32'h0800_0040, 6, 32'h10C, 1'b1, 32'h0000_0000); // j disabled
`endif

    for (int i = 0; i < nv; i++) begin
      load_default();
      mem[64] = vecs[i].setup;
      mem[65] = vecs[i].instr;
      mem[66] = PROBE;
      do_reset();
      repeat (20) step();
      check($sformatf("v%0d_delta", i), (ret_n >= 2) ? ret_cyc[1] - ret_cyc[0] : -1, vecs[i].delta);
      check($sformatf("v%0d_pc", i), (ret_n >= 2) ? ret_pc[1] : 32'hFFFF_FFFF, vecs[i].pc2);
      check($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      check($sformatf("v%0d_mem40", i), mem[16], vecs[i].m40);
    end

    // Zero-wait program: 5 instructions in 21 cycles, then sw r4 to expose r4
    load_default();
    mem[64] = 32'h2001_0005; // addi r1,r0,5
    mem[65] = 32'h2002_0007; // addi r2,r0,7
    mem[66] = 32'h0022_1820; // add  r3,r1,r2
    mem[67] = 32'hAC03_0040; // sw   r3,0x40(r0)
    mem[68] = 32'h8C04_0040; // lw   r4,0x40(r0)
    mem[69] = 32'hAC04_0044; // sw   r4,0x44(r0)
    do_reset();
    check("first_req",  {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, RST_PC);
    check("first_we",   {31'd0, mem_we}, 32'd0);
    repeat (30) step();
    check("prog_cycles",  (ret_n >= 5) ? ret_cyc[4] - 1 : -1, 21);
    check("prog_ret0_pc", (ret_n >= 1) ? ret_pc[0] : 32'hFFFF_FFFF, 32'h104);
    check("prog_ret4_pc", (ret_n >= 5) ? ret_pc[4] : 32'hFFFF_FFFF, 32'h114);
    check("prog_mem40",   mem[16], 32'd12);
    check("prog_mem44",   mem[17], 32'd12);

    // lw with 3 wait cycles in MEM: 8 cycles, address held for 4 cycles
    load_default();
    mem[16] = 32'h1234_5678;
    mem[64] = 32'h8C04_0040; // lw r4,0x40(r0)
    mem[65] = 32'hAC04_0044; // sw r4,0x44(r0)
    do_reset();
    stall_addr = 32'h40;
    stall_left = 3;
    stable_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req && !mem_we && mem_addr == 32'h40) stable_cnt++;
      step();
    end
    check("stall_hold",   stable_cnt, 4);
    check("stall_retire", (ret_n >= 1) ? ret_cyc[0] : -1, 9);
    check("stall_mem44",  mem[17], 32'h1234_5678);

    // Reset during a stalled access drops the request at once
    load_default();
    mem[64] = 32'h8C04_0040;
    do_reset();
    stall_addr = 32'h40;
    stall_left = 100;
    repeat (6) step();
    check("abort_req_before", {31'd0, mem_req}, 32'd1);
    check("abort_addr_before", mem_addr, 32'h40);
    rst = 1'b1;
    #1;
    check("abort_req_after", {31'd0, mem_req}, 32'd0);
    check("abort_pc_after",  pc, RST_PC);
    check("abort_retire",    ret_n, 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
